// File: rtl/fc_pkg.sv
// Shared types for the fully-connected layer sequencer: FP16 word, FSM state
// encoding and the FP16 adder used for the bias add.
package fc_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    BIAS  = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } fc_state_e;

  localparam fp16_t FP16_QNAN = 16'h7E00;

  // Float16Add: IEEE binary16 add, round-to-nearest-even, subnormals kept,
  // overflow to infinity, any NaN or inf-inf gives a quiet NaN.
  function automatic fp16_t fp16_add(input fp16_t a, input fp16_t b);
    logic [4:0]  ea;
    logic [4:0]  eb;
    logic [5:0]  ea_eff;
    logic [5:0]  eb_eff;
    logic [5:0]  el;
    logic [5:0]  es;
    logic [5:0]  d;
    logic [10:0] ma;
    logic [10:0] mb;
    logic [13:0] ml;
    logic [13:0] ms;
    logic [13:0] ms_sh;
    logic [13:0] mask;
    logic [14:0] sum;
    logic [11:0] rnd;
    logic        a_big;
    logic        sl;
    logic        sub;
    int          e;
    fp16_t       res;

    ea     = a[14:10];
    eb     = b[14:10];
    ma     = {ea != 5'd0, a[9:0]};
    mb     = {eb != 5'd0, b[9:0]};
    ea_eff = (ea == 5'd0) ? 6'd1 : {1'b0, ea};
    eb_eff = (eb == 5'd0) ? 6'd1 : {1'b0, eb};
    a_big  = (a[14:0] >= b[14:0]);
    sl     = a_big ? a[15] : b[15];
    el     = a_big ? ea_eff : eb_eff;
    es     = a_big ? eb_eff : ea_eff;
    ml     = a_big ? {ma, 3'b000} : {mb, 3'b000};
    ms     = a_big ? {mb, 3'b000} : {ma, 3'b000};
    sub    = a[15] ^ b[15];
    d      = el - es;

    // Alignment keeps guard/round bits and folds everything shifted out into a sticky bit.
    mask = '0;
    if (d >= 6'd14) begin
      ms_sh = {13'b0, |ms};
    end else begin
      mask  = ~(14'h3FFF << d);
      ms_sh = (ms >> d) | {13'b0, |(ms & mask)};
    end

    sum = sub ? ({1'b0, ml} - {1'b0, ms_sh}) : ({1'b0, ml} + {1'b0, ms_sh});
    e   = int'(el);
    if (sum[14]) begin
      sum = {1'b0, sum[14:2], sum[1] | sum[0]};
      e   = e + 1;
    end
    for (int k = 0; k < 13; k++) begin
      if (!sum[13] && e > 1) begin
        sum = sum << 1;
        e   = e - 1;
      end
    end

    rnd = {1'b0, sum[13:3]} + 12'(sum[2] & (sum[1] | sum[0] | sum[3]));
    if (rnd[11]) begin
      rnd = {1'b0, rnd[11:1]};
      e   = e + 1;
    end

    if (sum == 15'd0) begin
      res = {a[15] & b[15], 15'b0};
    end else if (e >= 31) begin
      res = {sl, 5'h1F, 10'h000};
    end else begin
      res = {sl, rnd[10] ? 5'(e) : 5'd0, rnd[9:0]};
    end

    if (ea == 5'h1F || eb == 5'h1F) begin
      if ((ea == 5'h1F && a[9:0] != '0) || (eb == 5'h1F && b[9:0] != '0)) begin
        res = FP16_QNAN;
      end else if (ea == 5'h1F && eb == 5'h1F && sub) begin
        res = FP16_QNAN;
      end else begin
        res = (ea == 5'h1F) ? a : b;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Feature/neuron counters for the FC sequencer; w_addr is kept as a running
// base plus offset so no multiplier is needed and it never exceeds IN_CH*OUT_CH-1.
module fc_addr_gen
  import fc_pkg::*;
#(
  parameter int IN_CH  = 120,
  parameter int OUT_CH = 84
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              mac_load,
  input  logic                              mac_step,
  input  logic                              neuron_next,
  input  logic                              pass_end,
  output logic [$clog2(IN_CH)-1:0]          img_addr,
  output logic [$clog2(IN_CH*OUT_CH)-1:0]   w_addr,
  output logic [$clog2(OUT_CH)-1:0]         bias_addr,
  output logic                              last_i,
  output logic                              last_o
);

  localparam int IW = $clog2(IN_CH);
  localparam int WW = $clog2(IN_CH * OUT_CH);
  localparam int OW = $clog2(OUT_CH);

  logic [WW-1:0] base;

  // img_addr is the feature counter i and bias_addr the neuron counter o.
  always_ff @(posedge clk) begin
    if (reset || pass_end) begin
      img_addr  <= '0;
      w_addr    <= '0;
      bias_addr <= '0;
      base      <= '0;
    end else begin
      if (mac_load) begin
        img_addr <= '0;
        w_addr   <= base;
      end else if (mac_step) begin
        img_addr <= img_addr + IW'(1);
        w_addr   <= w_addr + WW'(1);
      end
      if (neuron_next) begin
        bias_addr <= bias_addr + OW'(1);
        base      <= base + WW'(IN_CH);
      end
    end
  end

  assign last_i = (img_addr == IW'(IN_CH - 1));
  assign last_o = (bias_addr == OW'(OUT_CH - 1));

endmodule

// File: rtl/fc_sequencer.sv
// Fully-connected layer sequencer: walks neurons and features, drives an external
// FP16 MAC, adds the bias and emits one result per neuron. Define FC_RELU_EN to clamp negative sums to 0.
module fc_sequencer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_CH      = 120,
  parameter int OUT_CH     = 84,
  parameter int MAC_LAT    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(IN_CH)-1:0]        img_addr,
  output logic [$clog2(IN_CH*OUT_CH)-1:0] w_addr,
  output logic [$clog2(OUT_CH)-1:0]       bias_addr,
  output logic                            mac_clear,
  output logic                            mac_en,
  input  logic [DATA_WIDTH-1:0]           acc_in,
  input  logic [DATA_WIDTH-1:0]           bias_in,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [DATA_WIDTH-1:0]           res_data,
  output logic [$clog2(OUT_CH)-1:0]       res_ch,
  output fc_state_e                       dbg_state
);

  localparam int DCW = $clog2(MAC_LAT + 1) + 1;

  fc_state_e      state;
  logic [DCW-1:0] drain_cnt;
  logic           mac_load;
  logic           mac_step;
  logic           neuron_next;
  logic           pass_end;
  logic           last_i;
  logic           last_o;
  fp16_t          bias_sum;

  // Counter strobes decode the transition the FSM takes on this edge.
  assign mac_load    = (state == CLEAR);
  assign mac_step    = (state == MAC) && !last_i;
  assign neuron_next = (state == OUT) && res_ready && !last_o;
  assign pass_end    = (state == DONE);
  assign dbg_state   = state;

  fc_addr_gen #(
    .IN_CH  (IN_CH),
    .OUT_CH (OUT_CH)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .mac_load    (mac_load),
    .mac_step    (mac_step),
    .neuron_next (neuron_next),
    .pass_end    (pass_end),
    .img_addr    (img_addr),
    .w_addr      (w_addr),
    .bias_addr   (bias_addr),
    .last_i      (last_i),
    .last_o      (last_o)
  );

  always_comb begin
    bias_sum = fp16_add(acc_in, bias_in);
`ifdef FC_RELU_EN
    if (bias_sum[15]) bias_sum = '0;
`endif
  end

  // Result port: res_valid rises on entry to OUT and, with res_data/res_ch held
  // stable, stays high until a cycle with res_ready=1; that cycle is the transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_clear <= 1'b0;
      mac_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ch    <= '0;
      drain_cnt <= '0;
    end else begin
      mac_en    <= (state == MAC);
      done      <= 1'b0;
      mac_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            mac_clear <= 1'b1;
          end
        end
        CLEAR: state <= MAC;
        MAC: begin
          if (last_i) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          // The last mac_en lands in the first DRAIN cycle; acc_in settles MAC_LAT later.
          if (drain_cnt == DCW'(MAC_LAT)) state <= BIAS;
          else drain_cnt <= drain_cnt + DCW'(1);
        end
        BIAS: begin
          res_data  <= bias_sum;
          res_ch    <= bias_addr;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!last_o) begin
              state     <= CLEAR;
              mac_clear <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_sequencer.sv
// Bench for fc_sequencer (IN_CH=4, OUT_CH=2, MAC_LAT=2); honours FC_RELU_EN in its model.
`timescale 1ns/1ps
module tb_fc_sequencer;
  import fc_pkg::*;

  localparam int DW      = 16;
  localparam int IN_CH   = 4;
  localparam int OUT_CH  = 2;
  localparam int MAC_LAT = 2;
  localparam int IW      = $clog2(IN_CH);
  localparam int WW      = $clog2(IN_CH * OUT_CH);
  localparam int OW      = $clog2(OUT_CH);
  localparam int DONE_AT = OUT_CH * (IN_CH + MAC_LAT + 4) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          res_ready;
  logic          busy;
  logic          done;
  logic          mac_clear;
  logic          mac_en;
  logic          res_valid;
  logic [IW-1:0] img_addr;
  logic [WW-1:0] w_addr;
  logic [OW-1:0] bias_addr;
  logic [OW-1:0] res_ch;
  logic [DW-1:0] acc_in;
  logic [DW-1:0] bias_in;
  logic [DW-1:0] res_data;
  fc_state_e     dbg_state;

  logic [DW-1:0]    acc_tab  [OUT_CH];
  logic [DW-1:0]    bias_tab [OUT_CH];
  logic [OW+DW-1:0] exp_q[$];
  logic [IW+WW-1:0] exp_addr_q[$];
  logic [IW-1:0]    prev_img;
  logic [WW-1:0]    prev_w;
  int               n_checks = 0;
  int               n_errors = 0;
  bit               mon_en = 1'b0;

  always #5 clk = ~clk;

  assign acc_in  = acc_tab[bias_addr];
  assign bias_in = bias_tab[bias_addr];

  fc_sequencer #(
    .DATA_WIDTH (DW),
    .IN_CH      (IN_CH),
    .OUT_CH     (OUT_CH),
    .MAC_LAT    (MAC_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .img_addr  (img_addr),
    .w_addr    (w_addr),
    .bias_addr (bias_addr),
    .mac_clear (mac_clear),
    .mac_en    (mac_en),
    .acc_in    (acc_in),
    .bias_in   (bias_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ch    (res_ch),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic real fp16_to_real(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    v = (e == 0) ? real'(h[9:0]) / 1024.0 : 1.0 + real'(h[9:0]) / 1024.0;
    if (e == 0) e = 1;
    for (int k = 0; k < e - 15; k++) v = v * 2.0;
    for (int k = 0; k < 15 - e; k++) v = v / 2.0;
    return h[15] ? -v : v;
  endfunction

  // Only used on values that are exactly representable in FP16.
  function automatic logic [15:0] real_to_fp16(input real x);
    logic s;
    real  a;
    int   e;
    int   m;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 1024.0);
    return {s, 5'(e), 10'(m)};
  endfunction

  function automatic logic [DW-1:0] model_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = real_to_fp16(fp16_to_real(a) + fp16_to_real(b));
`ifdef FC_RELU_EN
    if (r[15]) r = 16'h0000;
`endif
    return r;
  endfunction

  // Multiples of 0.25 in [-64,64]: every sum is exact, so the real-valued model is exact too.
  function automatic logic [15:0] rand_val();
    int n;
    n = int'($urandom_range(0, 512)) - 256;
    return real_to_fp16(real'(n) / 4.0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int o = 0; o < OUT_CH; o++) begin
      acc_tab[o]  = rand_val();
      bias_tab[o] = rand_val();
    end
  endtask

  task automatic push_expect();
    for (int o = 0; o < OUT_CH; o++) begin
      exp_q.push_back({OW'(o), model_add(acc_tab[o], bias_tab[o])});
      for (int i = 0; i < IN_CH; i++) exp_addr_q.push_back({IW'(i), WW'(o * IN_CH + i)});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".mac_clear"}, mac_clear, 0);
    check({tag, ".mac_en"}, mac_en, 0);
    check({tag, ".res_valid"}, res_valid, 0);
    check({tag, ".res_data"}, res_data, 0);
    check({tag, ".res_ch"}, res_ch, 0);
    check({tag, ".img_addr"}, img_addr, 0);
    check({tag, ".w_addr"}, w_addr, 0);
    check({tag, ".bias_addr"}, bias_addr, 0);
    check({tag, ".state"}, dbg_state, IDLE);
  endtask

  // mac_en accumulates the operands at the previous cycle's addresses; results pop on transfer.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (mac_en) begin
        if (exp_addr_q.size() == 0) check("mac_en_extra", 32'(exp_addr_q.size()), 1);
        else check("mac_operand_addr", {prev_img, prev_w}, exp_addr_q.pop_front());
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("res_extra", 32'(exp_q.size()), 1);
        else check("res_ch_data", {res_ch, res_data}, exp_q.pop_front());
      end
    end
    prev_img = img_addr;
    prev_w   = w_addr;
  end

  // Called after the edge that sampled start; mode 0 ready=1, 1 random ready, 2 stall 5 cycles in first OUT.
  task automatic wait_pass(input bit timed, input int mode);
    int cyc        = 1;
    int done_cyc   = -1;
    int idle_cyc   = 0;
    int n_clear    = 0;
    int stall_left = 0;
    bit stalled    = 1'b0;
    while (done_cyc < 0 && cyc < 500) begin
      if (mac_clear) n_clear++;
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (!busy) idle_cyc++;
        case (mode)
          0: res_ready = 1'b1;
          1: res_ready = 1'($urandom_range(0, 1));
          default: begin
            if (res_valid && !stalled) begin
              stalled    = 1'b1;
              stall_left = 5;
            end
            if (stall_left > 0) begin
              check("stall_valid", res_valid, 1);
              check("stall_data", {res_ch, res_data}, exp_q[0]);
              check("stall_img", img_addr, IN_CH - 1);
              check("stall_w", w_addr, IN_CH - 1);
              check("stall_bias", bias_addr, 0);
              check("stall_state", dbg_state, OUT);
              stall_left--;
              res_ready = 1'b0;
            end else begin
              res_ready = 1'b1;
            end
          end
        endcase
        tick();
        cyc++;
      end
    end
    if (done_cyc < 0) begin
      check("pass_timeout", cyc, 0);
      exp_q.delete();
      exp_addr_q.delete();
    end else begin
      if (timed) check("done_cycle", done_cyc, DONE_AT);
      check("busy_in_pass", idle_cyc, 0);
      check("mac_clear_count", n_clear, OUT_CH);
      tick();
      check("done_width", done, 0);
      check("idle_after_done", dbg_state, IDLE);
      check("busy_after_done", busy, 0);
      check("bias_addr_after_done", bias_addr, 0);
      check("res_left", 32'(exp_q.size()), 0);
      check("addr_left", 32'(exp_addr_q.size()), 0);
    end
  endtask

  task automatic run_pass(input bit timed, input int mode, input bit hold_start);
    push_expect();
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    wait_pass(timed, mode);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    res_ready = 1'b0;
    for (int o = 0; o < OUT_CH; o++) begin
      acc_tab[o]  = '0;
      bias_tab[o] = '0;
    end
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    check("post_reset_state", dbg_state, IDLE);
    mon_en = 1'b1;

    // 1.0+2.0 on neuron 0, -3.0+1.0 on neuron 1
    acc_tab[0]  = 16'h3C00;
    bias_tab[0] = 16'h4000;
    acc_tab[1]  = 16'hC200;
    bias_tab[1] = 16'h3C00;
    run_pass(1'b1, 0, 1'b0);

    repeat (3) begin
      fill_random();
      run_pass(1'b0, 1, 1'b0);
    end

    fill_random();
    run_pass(1'b0, 2, 1'b0);

    // Abort in the third MAC cycle
    fill_random();
    push_expect();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("abort_pre_state", dbg_state, MAC);
    check("abort_pre_img", img_addr, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("abort");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (3) begin
      tick();
      check("abort_no_done", done, 0);
      check("abort_no_valid", res_valid, 0);
      check("abort_idle", dbg_state, IDLE);
    end
    run_pass(1'b1, 0, 1'b0);

    // start held across a whole pass
    fill_random();
    run_pass(1'b1, 0, 1'b1);
    push_expect();
    tick();
    check("restart_state", dbg_state, CLEAR);
    check("restart_busy", busy, 1);
    start = 1'b0;
    wait_pass(1'b1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_sequencer.md
FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, 16, FP16 word width.
REQ-002 Parameter IN_CH, 120, input features per output neuron.
REQ-003 Parameter OUT_CH, 84, output neurons.
REQ-004 Parameter MAC_LAT, 2, cycles from the last mac_en to a valid acc_in.
REQ-005 Port: clk  in  1  single clock, all logic on its rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: start  in  1  begins one layer pass when sampled in IDLE.
REQ-008 Port: busy  out  1  high in every state except IDLE.
REQ-009 Port: done  out  1  one-cycle pulse when the pass completes.
REQ-010 Port: img_addr  out  $clog2(IN_CH)  feature index i.
REQ-011 Port: w_addr  out  $clog2(IN_CH*OUT_CH)  weight index o*IN_CH+i.
REQ-012 Port: bias_addr  out  $clog2(OUT_CH)  current neuron o, held for the whole neuron.
REQ-013 Port: mac_clear  out  1  clears the external FP16 accumulator.
REQ-014 Port: mac_en  out  1  accumulates the operands read at the previous cycle's addresses.
REQ-015 Port: acc_in  in  DATA_WIDTH  accumulator value.
REQ-016 Port: bias_in  in  DATA_WIDTH  bias[bias_addr], stable while bias_addr is stable.
REQ-017 Port: res_valid/res_ready  out/in  1  result handshake.
REQ-018 Port: res_data  out  DATA_WIDTH  acc_in+bias_in, post-activation.
REQ-019 Port: res_ch  out  $clog2(OUT_CH)  neuron index of res_data.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, MAC, DRAIN, BIAS, OUT, DONE.
REQ-021 IDLE->CLEAR on start; start SHALL be ignored in all other states.
REQ-022 CLEAR SHALL last 1 cycle with mac_clear=1, then go to MAC with i=0.
REQ-023 MAC SHALL last IN_CH cycles and issue i=0..IN_CH-1, one per cycle.
REQ-024 mac_en SHALL be a one-cycle-delayed copy of "MAC state", giving exactly IN_CH pulses per neuron.
REQ-025 DRAIN SHALL last MAC_LAT+1 cycles, then go to BIAS.
REQ-026 BIAS SHALL register res_data=Float16Add(acc_in,bias_in) and res_ch=o in 1 cycle, then go to OUT.
REQ-027 OUT SHALL hold res_valid=1 with res_data and res_ch stable until res_ready=1.
REQ-028 On handshake in OUT: if o<OUT_CH-1, SHALL increment o and go to CLEAR; otherwise SHALL go to DONE.
REQ-029 DONE SHALL assert done for 1 cycle and then go to IDLE; o and i SHALL return to 0.
REQ-030 Per-neuron latency with res_ready=1 SHALL be IN_CH+MAC_LAT+4 cycles; no address SHALL advance outside MAC.
REQ-031 Outside MAC, img_addr and w_addr SHALL hold their last values; the w_addr computation SHALL not overflow for any parameter values.

Reset
REQ-032 Reset SHALL force IDLE with o=0, i=0, and busy, done, mac_clear, mac_en, res_valid, res_data, res_ch and all addresses at 0.
REQ-033 Reset mid-pass SHALL abort the pass with no done pulse and no res_valid in the following cycle.

Configuration
REQ-034 With FC_RELU_EN defined, res_data SHALL be 0x0000 when the sum's sign bit is 1; without it, res_data SHALL be the raw sum.

Structure
REQ-035 Package fc_pkg SHALL hold the fp16_t typedef and the fc_state_e state enum.
REQ-036 Sub-module fc_addr_gen (i/o counters and w_addr) is natural; Float16Add SHALL be reused for the bias add.

Verification (IN_CH=4, OUT_CH=2, MAC_LAT=2)
REQ-037 Start pulse, res_ready=1 -> w_addr 0,1,2,3 then 4,5,6,7; 4 mac_en pulses per neuron; done at cycle 21 after start.
REQ-038 acc_in=0x3C00, bias_in=0x4000 -> res_data=0x4200, res_ch=0.
REQ-039 acc_in=0xC200, bias_in=0x3C00 -> res_data=0xC000 without FC_RELU_EN; 0x0000 with it.
REQ-040 res_ready=0 for 5 cycles in OUT -> res_valid, res_data and res_ch stable, addresses frozen, then resume.
REQ-041 Reset asserted in the 3rd MAC cycle -> next cycle all outputs 0, IDLE, no done; a new start gives a full correct pass.
REQ-042 Start held high throughout the pass -> exactly one pass, done once, then a new pass begins from IDLE.
